hazard_unit: RTL and testbench

Pipeline hazard controller for the 16-bit core; it consumes the ID/EX, EX/MEM and MEM/WB register outputs and drives the pipeline-register write enables, bubble and flush controls. Detects load-use hazards and inserts bubbles, squashes on taken branches, and freezes the pipeline while data memory is busy. Also generates EX-stage forwarding selects and a saturating stall-cycle counter. Its `OIDEXWrite`/`OIDEXBubble` outputs drive the ID/EX register's enable and control-zeroing.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_unit_fwd_sel.sv | 25 ++
 rtl/hazard_unit.sv | 130 +++++++++++++
 tb/tb_hazard_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - state, forwarding-select and control-vector encodings shared by the hazard unit and EX muxes
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_LSTALL = 2'b01,
        ST_FLUSH  = 2'b10,
        ST_FREEZE = 2'b11
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Control vector order: {pc_write, ifid_write, idex_write, idex_bubble, ifid_flush}
    localparam logic [4:0] CTL_RUN    = 5'b11100;
    localparam logic [4:0] CTL_STALL  = 5'b00110;
    localparam logic [4:0] CTL_FLUSH  = 5'b11111;
    localparam logic [4:0] CTL_FREEZE = 5'b00000;
    localparam logic [4:0] CTL_RESET  = 5'b00111;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// rtl/hazard_unit_fwd_sel.sv - EX operand forwarding select for one source register
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_W = 16
) (
    input  logic [REG_W-1:0] ex_rs,
    input  logic             mem_we,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_we,
    input  logic [REG_W-1:0] wb_rd,
    output logic [1:0]       sel
);

    // The younger EX/MEM result wins over MEM/WB; register 0 is never forwarded.
    always_comb begin
        sel = FWD_RF;
        if (mem_we && (mem_rd != '0) && (mem_rd == ex_rs)) begin
            sel = FWD_MEM;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == ex_rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, branch flush, memory freeze and forwarding control for the 16-bit core
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_W        = 16,
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [REG_W-1:0] IIDRs1,
    input  logic [REG_W-1:0] IIDRs2,
    input  logic             IIDUsesRs2,
    input  logic             IEXMemRead,
    input  logic             IEXRegWrite,
    input  logic [REG_W-1:0] IEXRd,
    input  logic [REG_W-1:0] IEXRs1,
    input  logic [REG_W-1:0] IEXRs2,
    input  logic             IMEMRegWrite,
    input  logic [REG_W-1:0] IMEMRd,
    input  logic             IWBRegWrite,
    input  logic [REG_W-1:0] IWBRd,
    input  logic             IBranchTaken,
    input  logic             IMemBusy,
    output logic             OPCWrite,
    output logic             OIFIDWrite,
    output logic             OIDEXWrite,
    output logic             OIDEXBubble,
    output logic             OIFIDFlush,
    output logic [1:0]       OFwdA,
    output logic [1:0]       OFwdB,
    output logic [1:0]       OState,
    output logic [15:0]      OStallCnt
);

    localparam logic [15:0] LOAD_INIT  = (LOAD_STALL > 1)   ? 16'(LOAD_STALL - 1)   : 16'd0;
    localparam logic [15:0] FLUSH_INIT = (FLUSH_CYCLES > 1) ? 16'(FLUSH_CYCLES - 1) : 16'd0;

    hz_state_t   state, state_n;
    hz_state_t   saved, saved_n;
    hz_state_t   eff;
    logic [15:0] cnt, cnt_n;
    logic [15:0] stall_cnt;
    logic [4:0]  ctl;
    logic        lu;
    logic        lu_bubble;
    logic [1:0]  fwd_a, fwd_b;

    // IEXRegWrite is part of the ID/EX bundle but a load already implies the write.
    logic unused_ok;
    assign unused_ok = IEXRegWrite;

    assign lu = IEXMemRead && (IEXRd != '0) &&
                ((IEXRd == IIDRs1) || (IIDUsesRs2 && (IEXRd == IIDRs2)));

    always_comb begin
        eff       = (state == ST_FREEZE) ? saved : state;
        state_n   = ST_RUN;
        saved_n   = saved;
        cnt_n     = '0;
        ctl       = CTL_RUN;
        lu_bubble = 1'b0;
        if (IMemBusy) begin
            // Freeze remembers which state it interrupted so the count resumes intact.
            ctl     = CTL_FREEZE;
            state_n = ST_FREEZE;
            saved_n = eff;
            cnt_n   = cnt;
        end else if (IBranchTaken) begin
            ctl     = CTL_FLUSH;
            state_n = (FLUSH_INIT != '0) ? ST_FLUSH : ST_RUN;
            cnt_n   = FLUSH_INIT;
        end else if (((eff == ST_LSTALL) || (eff == ST_FLUSH)) && (cnt != '0)) begin
            cnt_n   = cnt - 16'd1;
            state_n = (cnt == 16'd1) ? ST_RUN : eff;
            if (eff == ST_FLUSH) begin
                ctl = CTL_FLUSH;
            end else begin
                ctl       = CTL_STALL;
                lu_bubble = 1'b1;
            end
        end else if (lu) begin
            ctl       = CTL_STALL;
            lu_bubble = 1'b1;
            state_n   = (LOAD_INIT != '0) ? ST_LSTALL : ST_RUN;
            cnt_n     = LOAD_INIT;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_RUN;
            saved     <= ST_RUN;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_n;
            saved <= saved_n;
            cnt   <= cnt_n;
            if (lu_bubble) begin
                stall_cnt <= sat_inc16(stall_cnt);
            end
        end
    end

    fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .ex_rs  (IEXRs1),
        .mem_we (IMEMRegWrite),
        .mem_rd (IMEMRd),
        .wb_we  (IWBRegWrite),
        .wb_rd  (IWBRd),
        .sel    (fwd_a)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .ex_rs  (IEXRs2),
        .mem_we (IMEMRegWrite),
        .mem_rd (IMEMRd),
        .wb_we  (IWBRegWrite),
        .wb_rd  (IWBRd),
        .sel    (fwd_b)
    );

    assign {OPCWrite, OIFIDWrite, OIDEXWrite, OIDEXBubble, OIFIDFlush} = Reset ? ctl : CTL_RESET;
    assign OFwdA     = Reset ? fwd_a : FWD_RF;
    assign OFwdB     = Reset ? fwd_b : FWD_RF;
    assign OState    = state;
    assign OStallCnt = stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit with LOAD_STALL=3, FLUSH_CYCLES=1
module tb_hazard_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [15:0] IIDRs1, IIDRs2, IEXRd, IEXRs1, IEXRs2, IMEMRd, IWBRd;
    logic        IIDUsesRs2, IEXMemRead, IEXRegWrite, IMEMRegWrite, IWBRegWrite;
    logic        IBranchTaken, IMemBusy;
    logic        OPCWrite, OIFIDWrite, OIDEXWrite, OIDEXBubble, OIFIDFlush;
    logic [1:0]  OFwdA, OFwdB, OState;
    logic [15:0] OStallCnt;

    always #5 CLK = ~CLK;

    hazard_unit #(.REG_W(16), .LOAD_STALL(3), .FLUSH_CYCLES(1)) u_dut (
        .CLK(CLK), .Reset(Reset),
        .IIDRs1(IIDRs1), .IIDRs2(IIDRs2), .IIDUsesRs2(IIDUsesRs2),
        .IEXMemRead(IEXMemRead), .IEXRegWrite(IEXRegWrite),
        .IEXRd(IEXRd), .IEXRs1(IEXRs1), .IEXRs2(IEXRs2),
        .IMEMRegWrite(IMEMRegWrite), .IMEMRd(IMEMRd),
        .IWBRegWrite(IWBRegWrite), .IWBRd(IWBRd),
        .IBranchTaken(IBranchTaken), .IMemBusy(IMemBusy),
        .OPCWrite(OPCWrite), .OIFIDWrite(OIFIDWrite), .OIDEXWrite(OIDEXWrite),
        .OIDEXBubble(OIDEXBubble), .OIFIDFlush(OIFIDFlush),
        .OFwdA(OFwdA), .OFwdB(OFwdB), .OState(OState), .OStallCnt(OStallCnt)
    );

    // {pc, ifid, idex, bubble, flush}
    localparam logic [4:0] C_NORM  = 5'b11100;
    localparam logic [4:0] C_STALL = 5'b00110;
    localparam logic [4:0] C_FLUSH = 5'b11111;
    localparam logic [4:0] C_FRZ   = 5'b00000;
    localparam logic [4:0] C_RST   = 5'b00111;

    logic [26:0] exp_q[$];
    string       nm_q[$];
    int          total = 0;
    int          bad   = 0;

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            logic [26:0] e, got;
            string       nm;
            e   = exp_q.pop_front();
            nm  = nm_q.pop_front();
            got = {OPCWrite, OIFIDWrite, OIDEXWrite, OIDEXBubble, OIFIDFlush,
                   OFwdA, OFwdB, OState, OStallCnt};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s: got ctl=%b fa=%b fb=%b st=%b sc=%0d, want ctl=%b fa=%b fb=%b st=%b sc=%0d",
                         nm, got[26:22], got[21:20], got[19:18], got[17:16], got[15:0],
                         e[26:22], e[21:20], e[19:18], e[17:16], e[15:0]);
            end
        end
    end

    task automatic idle();
        Reset = 1'b1;
        IIDRs1 = '0; IIDRs2 = '0; IIDUsesRs2 = 1'b0;
        IEXMemRead = 1'b0; IEXRegWrite = 1'b0; IEXRd = '0; IEXRs1 = '0; IEXRs2 = '0;
        IMEMRegWrite = 1'b0; IMEMRd = '0; IWBRegWrite = 1'b0; IWBRd = '0;
        IBranchTaken = 1'b0; IMemBusy = 1'b0;
    endtask

    task automatic load_use(input logic [15:0] rd);
        IEXMemRead = 1'b1; IEXRegWrite = 1'b1; IEXRd = rd; IIDRs1 = rd;
    endtask

    task automatic chk(input string nm, input logic [4:0] c, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [1:0] st, input logic [15:0] sc);
        exp_q.push_back({c, fa, fb, st, sc});
        nm_q.push_back(nm);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        Reset = 1'b0;
        load_use(16'd5);
        IMEMRegWrite = 1'b1; IMEMRd = 16'd3; IEXRs1 = 16'd3;
        @(posedge CLK);
        #1;
        chk("rst0", C_RST, 2'b00, 2'b00, 2'b00, 16'd0);
        IBranchTaken = 1'b1; IMemBusy = 1'b1;
        chk("rst1", C_RST, 2'b00, 2'b00, 2'b00, 16'd0);

        idle();                                   chk("release", C_NORM, 2'b00, 2'b00, 2'b00, 16'd0);
        idle(); IEXMemRead = 1'b1; IEXRd = 16'd5; IIDRs1 = 16'd1; IIDRs2 = 16'd5;
                                                  chk("rs2_unused", C_NORM, 2'b00, 2'b00, 2'b00, 16'd0);
        idle(); IEXMemRead = 1'b1;                chk("rd_zero", C_NORM, 2'b00, 2'b00, 2'b00, 16'd0);

        idle(); IEXMemRead = 1'b1; IEXRd = 16'd5; IIDRs1 = 16'd1; IIDRs2 = 16'd5; IIDUsesRs2 = 1'b1;
                                                  chk("lu_rs2", C_STALL, 2'b00, 2'b00, 2'b00, 16'd0);
        idle();                                   chk("lstall1", C_STALL, 2'b00, 2'b00, 2'b01, 16'd1);
        idle();                                   chk("lstall2", C_STALL, 2'b00, 2'b00, 2'b01, 16'd2);
        idle();                                   chk("lstall_end", C_NORM, 2'b00, 2'b00, 2'b00, 16'd3);

        idle(); load_use(16'd7);                  chk("lu_br0", C_STALL, 2'b00, 2'b00, 2'b00, 16'd3);
        idle(); IBranchTaken = 1'b1;              chk("br_in_lstall", C_FLUSH, 2'b00, 2'b00, 2'b01, 16'd4);
        idle();                                   chk("br_cancel", C_NORM, 2'b00, 2'b00, 2'b00, 16'd4);

        idle(); load_use(16'd7);                  chk("lu_frz0", C_STALL, 2'b00, 2'b00, 2'b00, 16'd4);
        idle();                                   chk("lu_frz1", C_STALL, 2'b00, 2'b00, 2'b01, 16'd5);
        idle(); IMemBusy = 1'b1;                  chk("freeze0", C_FRZ, 2'b00, 2'b00, 2'b01, 16'd6);
        idle(); IMemBusy = 1'b1;                  chk("freeze1", C_FRZ, 2'b00, 2'b00, 2'b11, 16'd6);
        idle(); IMemBusy = 1'b1;                  chk("freeze2", C_FRZ, 2'b00, 2'b00, 2'b11, 16'd6);
        idle();                                   chk("resume", C_STALL, 2'b00, 2'b00, 2'b11, 16'd6);
        idle();                                   chk("resume_run", C_NORM, 2'b00, 2'b00, 2'b00, 16'd7);

        idle(); load_use(16'd7); IBranchTaken = 1'b1;
                                                  chk("br_over_lu", C_FLUSH, 2'b00, 2'b00, 2'b00, 16'd7);
        idle();                                   chk("br_done", C_NORM, 2'b00, 2'b00, 2'b00, 16'd7);

        idle(); load_use(16'd2); IMemBusy = 1'b1; chk("frz_over_lu", C_FRZ, 2'b00, 2'b00, 2'b00, 16'd7);
        idle(); load_use(16'd2);                  chk("lu_after_frz", C_STALL, 2'b00, 2'b00, 2'b11, 16'd7);
        idle();                                   chk("lu_af1", C_STALL, 2'b00, 2'b00, 2'b01, 16'd8);
        idle();                                   chk("lu_af2", C_STALL, 2'b00, 2'b00, 2'b01, 16'd9);
        idle();                                   chk("lu_af_end", C_NORM, 2'b00, 2'b00, 2'b00, 16'd10);

        idle(); IEXRs1 = 16'd3; IMEMRd = 16'd3; IWBRd = 16'd3; IMEMRegWrite = 1'b1; IWBRegWrite = 1'b1;
                                                  chk("fwd_a_mem", C_NORM, 2'b10, 2'b00, 2'b00, 16'd10);
        IMEMRegWrite = 1'b0;                      chk("fwd_a_wb", C_NORM, 2'b01, 2'b00, 2'b00, 16'd10);
        idle(); IEXRs2 = 16'd4; IMEMRd = 16'd4; IWBRd = 16'd4; IMEMRegWrite = 1'b1; IWBRegWrite = 1'b1;
                                                  chk("fwd_b_mem", C_NORM, 2'b00, 2'b10, 2'b00, 16'd10);
        IMEMRegWrite = 1'b0;                      chk("fwd_b_wb", C_NORM, 2'b00, 2'b01, 2'b00, 16'd10);
        idle(); IMEMRegWrite = 1'b1; IWBRegWrite = 1'b1;
                                                  chk("fwd_zero", C_NORM, 2'b00, 2'b00, 2'b00, 16'd10);
        idle(); IEXRs1 = 16'd6; IEXRs2 = 16'd6; IMEMRd = 16'd6; IWBRd = 16'd6;
                                                  chk("fwd_nowe", C_NORM, 2'b00, 2'b00, 2'b00, 16'd10);

        idle(); load_use(16'd9);                  chk("lu_rst", C_STALL, 2'b00, 2'b00, 2'b00, 16'd10);
        idle(); Reset = 1'b0;                     chk("rst_mid", C_RST, 2'b00, 2'b00, 2'b00, 16'd0);
        idle();                                   chk("rst_rel0", C_NORM, 2'b00, 2'b00, 2'b00, 16'd0);
        idle();                                   chk("rst_rel1", C_NORM, 2'b00, 2'b00, 2'b00, 16'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
